// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM array.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned BYTE_OFS_W = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone,
    StRelease
  } state_e;

  typedef enum logic {
    OpRd,
    OpWr
  } op_e;

  // Wait counter load value; zero waits bypass BUSY so the value is unused then.
  function automatic logic [CNT_W-1:0] cnt_init(input int unsigned waits);
    return (waits == 0) ? '0 : CNT_W'(waits - 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 64-bit words, registered read with a zero-load for faulted reads.
module dmem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          re_i,
  input  logic          clr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= clr_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: LDUR/STUR on a 64-bit RAM with wait states and a one-cycle ack.
// Build option: define DMEM_MISALIGN_TRAP_EN to flag non-word-aligned addresses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned AW          = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        ramW,
  input  logic        EN_MEM,
  input  logic [63:0] address,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        rdata_oe,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam logic [CNT_W-1:0] CntInit = cnt_init(WAIT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             to_done;

  op_e              acc_op;
  logic [AW-1:0]    acc_idx;
  logic             acc_err;
  logic             range_err;

  // Write wins when both enables are set.
  assign acc_op    = ramW ? OpWr : OpRd;
  assign acc_idx   = address[AW+BYTE_OFS_W-1:BYTE_OFS_W];
  assign range_err = (address >> (AW + BYTE_OFS_W)) != 64'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign acc_err = range_err || (address[BYTE_OFS_W-1:0] != '0);
`else
  logic unused_ofs;
  assign unused_ofs = ^address[BYTE_OFS_W-1:0];
  assign acc_err    = range_err;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    to_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && (ramW || EN_MEM)) begin
          op_d    = acc_op;
          idx_d   = acc_idx;
          wdata_d = wdata;
          err_d   = acc_err;
          cnt_d   = CntInit;
          if (WAIT_CYCLES == 0) begin
            state_d = StDone;
            to_done = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          to_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone:    state_d = StRelease;
      StRelease: begin
        if (!req_valid) begin
          state_d = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpRd;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // The RAM is driven from the _d operands so a zero-wait accept reaches it on the same edge.
  logic mem_we, mem_re;
  assign mem_we = to_done && (op_d == OpWr) && !err_d;
  assign mem_re = to_done && (op_d == OpRd);

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .clr_i   (err_d),
    .addr_i  (idx_d),
    .wdata_i (wdata_d),
    .rdata_o (rdata)
  );

  assign ack      = (state_q == StDone);
  assign busy     = (state_q != StIdle);
  assign rdata_oe = ((state_q == StDone) || (state_q == StRelease)) && (op_q == OpRd);
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level memory model checked every cycle.
module tb_dmem_responder;

  localparam int unsigned W = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        ramW = 1'b0;
  logic        EN_MEM = 1'b0;
  logic [63:0] address = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        rdata_oe, ack, err, busy;

  int n_chk = 0;
  int n_pass = 0;

  dmem_responder #(
    .DEPTH       (256),
    .WAIT_CYCLES (W),
    .AW          (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .ramW      (ramW),
    .EN_MEM    (EN_MEM),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_oe  (rdata_oe),
    .ack       (ack),
    .err       (err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Transaction model: an access occupies the engine from accept until the request drops
  // after completion; its memory effect lands on the ack cycle.
  int unsigned cyc = 0;
  bit          m_act = 1'b0;
  int unsigned m_ack_at = 0;
  bit          t_wr = 1'b0, t_rd = 1'b0, t_err = 1'b0;
  int          t_idx = 0;
  logic [63:0] t_wd = '0;
  logic [63:0] mmem [int];
  logic [63:0] e_rdata = '0;
  bit          e_known = 1'b1;
  bit          e_err = 1'b0;

  function automatic bit addr_err(input logic [63:0] a);
    bit e;
    e = (a >> 11) != 64'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    e = e || ((a % 64'd8) != 64'd0);
`endif
    return e;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_act   = 1'b0;
      e_rdata = '0;
      e_known = 1'b1;
      e_err   = 1'b0;
    end else begin
      cyc++;
      if (m_act && cyc >= m_ack_at + 2 && !req_valid) begin
        m_act = 1'b0;
      end else if (!m_act && req_valid && (ramW || EN_MEM)) begin
        m_act    = 1'b1;
        m_ack_at = cyc + W;
        t_wr     = ramW;
        t_rd     = !ramW;
        t_err    = addr_err(address);
        t_idx    = int'(address[10:3]);
        t_wd     = wdata;
      end
      if (m_act && cyc == m_ack_at) begin
        e_err = t_err;
        if (t_wr && !t_err) mmem[t_idx] = t_wd;
        if (t_rd) begin
          if (t_err) begin
            e_rdata = '0;
            e_known = 1'b1;
          end else if (mmem.exists(t_idx)) begin
            e_rdata = mmem[t_idx];
            e_known = 1'b1;
          end else begin
            e_known = 1'b0;
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;
  bit e_ack;
  always @(negedge clock) begin
    if (chk_en) begin
      e_ack = m_act && (cyc == m_ack_at);
      check("ack", ack, e_ack);
      check("busy", busy, m_act);
      check("rdata_oe", rdata_oe, m_act && t_rd && (cyc >= m_ack_at));
      if (e_known) check("rdata", rdata, e_rdata);
      if (e_ack) check("err", err, e_err);
      else if (!reset_n) check("err_rst", err, 0);
    end
  end

  int ack_cnt = 0;
  always @(negedge clock) if (ack) ack_cnt++;

  // Operands are scrambled after accept to show they were latched.
  task automatic access(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                        input int hold, output logic [63:0] rd, output logic er, output int lat);
    @(posedge clock); #1;
    req_valid = 1'b1; ramW = w; EN_MEM = r; address = a; wdata = d;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clock); #1;
      if (ack) begin
        lat = i; rd = rdata; er = err;
      end
      if (i == 1) begin
        address = ~a; wdata = ~d;
      end
    end
    if (lat == 0) check("ack_timeout", 0, 1);
    repeat (hold) @(posedge clock);
    #1;
    req_valid = 1'b0; ramW = 1'b0; EN_MEM = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          a0;

  initial begin
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk_en = 1'b1;
    @(posedge clock); #1;
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_oe", rdata_oe, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Preload known words.
    access(1, 0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 0, rd, er, lat);
    access(1, 0, 64'h10, 64'h1111_2222_3333_4444, 0, rd, er, lat);
    access(0, 1, 64'h10, 64'h0, 0, rd, er, lat);
    check("pre_ld10", rd, 64'h1111_2222_3333_4444);

    // Reset one cycle after a store is accepted.
    a0 = ack_cnt;
    @(posedge clock); #1;
    req_valid = 1'b1; ramW = 1'b1; address = 64'h10; wdata = 64'hDEAD_BEEF_0000_0001;
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0; req_valid = 1'b0; ramW = 1'b0;
    @(posedge clock); #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_oe", rdata_oe, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("mid_rst_no_ack", ack_cnt - a0, 0);
    access(0, 1, 64'h10, 64'h0, 0, rd, er, lat);
    check("mid_rst_old", rd, 64'h1111_2222_3333_4444);

    // Store then load.
    access(1, 0, 64'h18, 64'h0123_4567_89AB_CDEF, 0, rd, er, lat);
    check("st_lat", lat, 3);
    check("st_err", er, 0);
    access(0, 1, 64'h18, 64'h0, 0, rd, er, lat);
    check("ld_lat", lat, 3);
    check("ld_data", rd, 64'h0123_4567_89AB_CDEF);
    check("ld_err", er, 0);
    check("ld_oe_idle", rdata_oe, 0);

    // Held request after a store: one write, one ack.
    a0 = ack_cnt;
    access(1, 0, 64'h28, 64'h55, 10, rd, er, lat);
    check("hold_acks", ack_cnt - a0, 1);
    access(0, 1, 64'h28, 64'h0, 0, rd, er, lat);
    check("hold_data", rd, 64'h55);

    // Out-of-range load and store (0x800 aliases word 0 in the index bits).
    access(0, 1, 64'h800, 64'h0, 0, rd, er, lat);
    check("oor_ld_err", er, 1);
    check("oor_ld_data", rd, 0);
    access(1, 0, 64'h800, 64'hBAD, 0, rd, er, lat);
    check("oor_st_err", er, 1);
    access(0, 1, 64'h0, 64'h0, 0, rd, er, lat);
    check("oor_st_nowr", rd, 64'hAAAA_AAAA_AAAA_AAAA);

    // Both enables: store only.
    access(1, 1, 64'h20, 64'h5, 0, rd, er, lat);
    check("both_rdata", rdata, 64'hAAAA_AAAA_AAAA_AAAA);
    access(0, 1, 64'h20, 64'h0, 0, rd, er, lat);
    check("both_wr", rd, 64'h5);

    // Misaligned load.
    access(0, 1, 64'h1B, 64'h0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_err", er, 1);
    check("mis_data", rd, 0);
`else
    check("mis_err", er, 0);
    check("mis_data", rd, 64'h0123_4567_89AB_CDEF);
`endif

    repeat (2) @(posedge clock);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
